// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU op codes and arbiter FSM encodings; the ALU, its decoder and the arbiter all agree on these.
// Codes above ALU_OP_MAX are undefined and never reach a requester as data.
package alu_share_arbiter_pkg;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_SLL    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_SLT    = 4'd8;
    localparam logic [3:0] ALU_SLTU   = 4'd9;
    localparam logic [3:0] ALU_OP_MAX = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= ALU_OP_MAX);
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request fan-in, shared response channel and ALU drive of the shared-ALU arbiter.
// master = requesters/consumer/ALU side, slave = arbiter side.
interface alu_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int XLEN    = 32
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [4*NUM_REQ-1:0]    req_op;
    logic [XLEN*NUM_REQ-1:0] req_a;
    logic [XLEN*NUM_REQ-1:0] req_b;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [XLEN-1:0]         rsp_data;
    logic                    rsp_err;

    logic [XLEN-1:0]         alu_a;
    logic [XLEN-1:0]         alu_b;
    logic [3:0]              alu_op;
    logic [XLEN-1:0]         alu_result;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready, alu_result,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, alu_a, alu_b, alu_op
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready, alu_result,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, alu_a, alu_b, alu_op
    );

endinterface

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping at NUM_REQ.
// Zero latency; gnt is one-hot or zero and never selects an idle request.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld
);

    localparam int             CW    = IDX_W + 1;
    localparam logic [CW-1:0]  N_CNT = CW'(NUM_REQ);

    // One spare bit so ptr + offset can exceed NUM_REQ before the wrap.
    logic [CW-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + CW'(i);
            if (cand >= N_CNT) begin
                cand = cand - N_CNT;
            end
            if (!gnt_vld && req[cand[IDX_W-1:0]]) begin
                gnt_vld                 = 1'b1;
                gnt_idx                 = cand[IDX_W-1:0];
                gnt[cand[IDX_W-1:0]]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU; operands registered, result returned 2 cycles after accept.
// Response held until rsp_ready; no new request is accepted while a response is stalled.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int XLEN    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_share_arbiter_if.slave  bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e            state_q,    state_d;
    logic [IDX_W-1:0]  ptr_q,      ptr_d;
    logic [3:0]        alu_op_q,   alu_op_d;
    logic [XLEN-1:0]   alu_a_q,    alu_a_d;
    logic [XLEN-1:0]   alu_b_q,    alu_b_d;
    logic [ID_W-1:0]   rsp_id_q,   rsp_id_d;
    logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
    logic              rsp_err_q,  rsp_err_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_vld;
    logic               accept;

    logic [3:0]         sel_op;
    logic [XLEN-1:0]    sel_a;
    logic [XLEN-1:0]    sel_b;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req     (bus.req_valid),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_op = bus.req_op[4*i +: 4];
                sel_a  = bus.req_a[XLEN*i +: XLEN];
                sel_b  = bus.req_b[XLEN*i +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            alu_op_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            alu_op_q   <= alu_op_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        alu_op_d   = alu_op_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    alu_op_d = sel_op;
                    alu_a_d  = sel_a;
                    alu_b_d  = sel_b;
                    rsp_id_d = ID_W'(arb_idx);
                    ptr_d    = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : IDX_W'(arb_idx + 1'b1);
                    state_d  = S_EXEC;
                end else if ((state_q == S_RESP) && bus.rsp_ready) begin
                    state_d  = S_IDLE;
                end
            end
            S_EXEC: begin
                // Undefined codes leave a stale value on the ALU output, so it is not forwarded.
                state_d = S_RESP;
                if (op_is_legal(alu_op_q)) begin
                    rsp_data_d = bus.alu_result;
                    rsp_err_d  = 1'b0;
                end else begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        case (state_q)
            S_IDLE:  accept = arb_vld;
            S_RESP:  accept = arb_vld & bus.rsp_ready;
            default: accept = 1'b0;
        endcase
        bus.req_ready = accept ? arb_gnt : '0;
        bus.rsp_valid = (state_q == S_RESP);
        bus.rsp_id    = rsp_id_q;
        bus.rsp_data  = rsp_data_q;
        bus.rsp_err   = rsp_err_q;
        bus.alu_op    = alu_op_q;
        bus.alu_a     = alu_a_q;
        bus.alu_b     = alu_b_q;
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomised and directed bench for the shared-ALU arbiter with a behavioural ALU and round-robin model.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int IW = 2;
    localparam int XL = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    alu_share_arbiter_if #(.NUM_REQ(NR), .ID_W(IW), .XLEN(XL)) bus ();

    alu_share_arbiter #(.NUM_REQ(NR), .ID_W(IW), .XLEN(XL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return $unsigned($signed(a) >>> b[4:0]);
            4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // The ALU leaves garbage on its output for undefined codes.
    assign bus.alu_result = (bus.alu_op <= 4'd9) ? ref_alu(bus.alu_op, bus.alu_a, bus.alu_b) : 32'hDEAD_BEEF;

    task automatic set_req(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_op[r*4 +: 4] = op;
        bus.req_a[r*32 +: 32] = a;
        bus.req_b[r*32 +: 32] = b;
    endtask

    // Drives one request alone and reports what came back; leaves the response handshaking at the next edge.
    task automatic issue_one(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic acc, output int lat, output logic [IW-1:0] id,
                             output logic [31:0] d, output logic e);
        acc = 1'b0; lat = 0; id = '0; d = '0; e = 1'b0;
        @(negedge clk);
        set_req(r, op, a, b);
        bus.req_valid    = '0;
        bus.req_valid[r] = 1'b1;
        bus.rsp_ready    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (bus.req_ready[r]) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.req_valid[r] = 1'b0;
        set_req(r, 4'($urandom), $urandom, $urandom);
        for (int k = 1; k <= 8; k++) begin
            #1;
            if (bus.rsp_valid) begin
                lat = k; id = bus.rsp_id; d = bus.rsp_data; e = bus.rsp_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = '0; bus.rsp_ready = 1'b0;
        bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
        n_checks++; if (bus.req_ready !== 4'b0) begin n_err++; $display("FAIL reset_req_ready got %b exp 0", bus.req_ready); end
        n_checks++; if (bus.rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id got %0d exp 0", bus.rsp_id); end
        n_checks++; if (bus.rsp_data !== 32'd0) begin n_err++; $display("FAIL reset_rsp_data got %h exp 0", bus.rsp_data); end
        n_checks++; if (bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err got %b exp 0", bus.rsp_err); end
        n_checks++; if (bus.alu_a !== 32'd0) begin n_err++; $display("FAIL reset_alu_a got %h exp 0", bus.alu_a); end
        n_checks++; if (bus.alu_b !== 32'd0) begin n_err++; $display("FAIL reset_alu_b got %h exp 0", bus.alu_b); end
        n_checks++; if (bus.alu_op !== 4'd0) begin n_err++; $display("FAIL reset_alu_op got %h exp 0", bus.alu_op); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL idle_rsp_ready_ignored rsp_valid got %b exp 0", bus.rsp_valid); end
    endtask

    task automatic test_single_add();
        logic acc, e; int lat; logic [IW-1:0] id; logic [31:0] d;
        issue_one(0, ALU_ADD, 32'd5, 32'd7, acc, lat, id, d, e);
        n_checks++; if (acc !== 1'b1) begin n_err++; $display("FAIL add_accept got %b exp 1", acc); end
        n_checks++; if (lat !== 2) begin n_err++; $display("FAIL add_latency got %0d exp 2", lat); end
        n_checks++; if (d !== 32'd12) begin n_err++; $display("FAIL add_data got %h exp 0000000c", d); end
        n_checks++; if (id !== 2'd0) begin n_err++; $display("FAIL add_id got %0d exp 0", id); end
        n_checks++; if (e !== 1'b0) begin n_err++; $display("FAIL add_err got %b exp 0", e); end
        n_checks++; if (bus.alu_a !== 32'd5 || bus.alu_b !== 32'd7 || bus.alu_op !== ALU_ADD) begin
            n_err++; $display("FAIL add_alu_drive got a=%h b=%h op=%h exp a=5 b=7 op=0", bus.alu_a, bus.alu_b, bus.alu_op);
        end
    endtask

    task automatic test_compare_shift();
        logic acc, e; int lat; logic [IW-1:0] id; logic [31:0] d;
        logic [3:0]  ops [3] = '{ALU_SLT, ALU_SLTU, ALU_SRA};
        logic [31:0] as  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] bs  [3] = '{32'd1, 32'd1, 32'd4};
        logic [31:0] exp [3] = '{32'd1, 32'd0, 32'hF800_0000};
        for (int i = 0; i < 3; i++) begin
            issue_one(2, ops[i], as[i], bs[i], acc, lat, id, d, e);
            n_checks++; if (d !== exp[i] || e !== 1'b0) begin n_err++; $display("FAIL cmp_shift_%0d got data=%h err=%b exp data=%h err=0", i, d, e, exp[i]); end
            n_checks++; if (id !== 2'd2 || lat !== 2) begin n_err++; $display("FAIL cmp_shift_id_%0d got id=%0d lat=%0d exp id=2 lat=2", i, id, lat); end
        end
    endtask

    task automatic test_random_ops();
        logic acc, e; int lat; logic [IW-1:0] id; logic [31:0] d;
        int r; logic [3:0] op; logic [31:0] a, b, exp_d; logic exp_e;
        for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, NR-1); op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom;
            exp_e = (op > 4'd9);
            exp_d = exp_e ? 32'd0 : ref_alu(op, a, b);
            issue_one(r, op, a, b, acc, lat, id, d, e);
            n_checks++; if (acc !== 1'b1 || lat !== 2) begin n_err++; $display("FAIL rand_%0d_timing got acc=%b lat=%0d exp acc=1 lat=2", i, acc, lat); end
            n_checks++; if (id !== IW'(r)) begin n_err++; $display("FAIL rand_%0d_id got %0d exp %0d", i, id, r); end
            n_checks++; if (d !== exp_d || e !== exp_e) begin n_err++; $display("FAIL rand_%0d_result op=%0d got %h/%b exp %h/%b", i, op, d, e, exp_d, exp_e); end
        end
    endtask

    task automatic test_round_robin();
        int ptr_m, pend, exp_g, obs_g, n_rsp, idx;
        int q_id[$]; logic [31:0] q_d[$]; logic q_e[$]; int grants[$];
        logic [3:0] op [NR]; logic [31:0] a [NR]; logic [31:0] b [NR];
        logic [NR-1:0] exp_rdy;
        int first5 [5] = '{0, 1, 2, 3, 0};
        @(negedge clk);
        rst_n = 1'b0; bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) begin
            op[i] = 4'($urandom_range(0, 15)); a[i] = $urandom; b[i] = $urandom;
            set_req(i, op[i], a[i], b[i]);
        end
        bus.rsp_ready = 1'b1;
        ptr_m = 0; pend = -1; n_rsp = 0;
        @(negedge clk);
        bus.req_valid = '1;
        for (int c = 0; c < 24; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 20) bus.req_valid = '0;
            if (pend >= 0) begin
                op[pend] = 4'($urandom_range(0, 15)); a[pend] = $urandom; b[pend] = $urandom;
                set_req(pend, op[pend], a[pend], b[pend]);
                pend = -1;
            end
            #1;
            if (bus.rsp_valid && bus.rsp_ready) begin
                n_rsp++;
                n_checks++;
                if (q_id.size() == 0) begin
                    n_err++; $display("FAIL rr_spurious_rsp got id=%0d exp no response", bus.rsp_id);
                end else begin
                    if (bus.rsp_id !== IW'(q_id[0]) || bus.rsp_data !== q_d[0] || bus.rsp_err !== q_e[0]) begin
                        n_err++; $display("FAIL rr_rsp got id=%0d data=%h err=%b exp id=%0d data=%h err=%b",
                                          bus.rsp_id, bus.rsp_data, bus.rsp_err, q_id[0], q_d[0], q_e[0]);
                    end
                    void'(q_id.pop_front()); void'(q_d.pop_front()); void'(q_e.pop_front());
                end
            end
            if (bus.req_ready != '0) begin
                exp_g = -1;
                for (int k = 0; k < NR; k++) begin
                    idx = (ptr_m + k) % NR;
                    if (bus.req_valid[idx]) begin exp_g = idx; break; end
                end
                obs_g = -1;
                for (int k = 0; k < NR; k++) if (bus.req_ready[k]) obs_g = k;
                exp_rdy = '0;
                if (exp_g >= 0) exp_rdy[exp_g] = 1'b1;
                n_checks++; if (bus.req_ready !== exp_rdy) begin n_err++; $display("FAIL rr_grant got %b exp %b", bus.req_ready, exp_rdy); end
                grants.push_back(obs_g);
                if (exp_g >= 0) begin
                    q_id.push_back(exp_g);
                    q_d.push_back((op[exp_g] > 4'd9) ? 32'd0 : ref_alu(op[exp_g], a[exp_g], b[exp_g]));
                    q_e.push_back(op[exp_g] > 4'd9);
                    ptr_m = (exp_g + 1) % NR;
                    pend  = exp_g;
                end
            end
        end
        n_checks++; if (grants.size() != 10) begin n_err++; $display("FAIL rr_throughput_grants got %0d exp 10", grants.size()); end
        n_checks++; if (n_rsp != 10 || q_id.size() != 0) begin n_err++; $display("FAIL rr_throughput_rsps got %0d left %0d exp 10 left 0", n_rsp, q_id.size()); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (i >= grants.size()) begin n_err++; $display("FAIL rr_order_%0d got none exp %0d", i, first5[i]); end
            else if (grants[i] != first5[i]) begin n_err++; $display("FAIL rr_order_%0d got %0d exp %0d", i, grants[i], first5[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a1, b1, a3, b3;
        a1 = $urandom; b1 = $urandom; a3 = $urandom; b3 = $urandom;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        set_req(1, ALU_XOR, a1, b1);
        bus.req_valid = 4'b0010;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_accept got %b exp 0010", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 4'b1000;
        set_req(1, 4'($urandom), $urandom, $urandom);
        set_req(3, ALU_OR, a3, b3);
        #1;
        n_checks++; if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_exec got rdy=%b vld=%b exp rdy=0000 vld=0", bus.req_ready, bus.rsp_valid); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_data !== (a1 ^ b1) || bus.rsp_err !== 1'b0 || bus.req_ready !== 4'b0000) begin
                n_err++; $display("FAIL bp_hold_%0d got vld=%b id=%0d data=%h err=%b rdy=%b exp vld=1 id=1 data=%h err=0 rdy=0000",
                                  k, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, bus.req_ready, a1 ^ b1);
            end
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        #1;
        n_checks++; if (bus.req_ready !== 4'b1000) begin n_err++; $display("FAIL bp_release_grant got %b exp 1000", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_after_release_vld got %b exp 0", bus.rsp_valid); end
        @(negedge clk);
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd3 || bus.rsp_data !== (a3 | b3)) begin
            n_err++; $display("FAIL bp_next_rsp got vld=%b id=%0d data=%h exp vld=1 id=3 data=%h", bus.rsp_valid, bus.rsp_id, bus.rsp_data, a3 | b3);
        end
    endtask

    task automatic test_illegal();
        logic acc, e; int lat; logic [IW-1:0] id; logic [31:0] d;
        issue_one(1, 4'd12, $urandom, $urandom, acc, lat, id, d, e);
        n_checks++; if (e !== 1'b1 || d !== 32'd0 || id !== 2'd1) begin n_err++; $display("FAIL illegal_op got err=%b data=%h id=%0d exp err=1 data=0 id=1", e, d, id); end
        issue_one(1, ALU_SUB, 32'd3, 32'd5, acc, lat, id, d, e);
        n_checks++; if (e !== 1'b0 || d !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL after_illegal_sub got err=%b data=%h exp err=0 data=fffffffe", e, d); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        logic [31:0] a1, b1, a3, b3;
        a1 = $urandom; b1 = $urandom; a3 = $urandom; b3 = $urandom;
        @(negedge clk);
        set_req(1, ALU_ADD, $urandom, $urandom);
        bus.req_valid = 4'b0010; bus.rsp_ready = 1'b1;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL rst_mid_accept got %b exp 0010", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b0 || bus.alu_a !== 32'd0 || bus.alu_op !== 4'd0 || bus.rsp_id !== 2'd0) begin
            n_err++; $display("FAIL rst_mid_clear got vld=%b alu_a=%h alu_op=%h id=%0d exp all 0", bus.rsp_valid, bus.alu_a, bus.alu_op, bus.rsp_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            if (bus.rsp_valid) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_err++; $display("FAIL rst_mid_no_rsp got response exp none"); end
        @(negedge clk);
        set_req(1, ALU_SUB, a1, b1);
        set_req(3, ALU_AND, a3, b3);
        bus.req_valid = 4'b1010;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL rst_mid_ptr0 got %b exp 0010", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 4'b1000;
        #1;
        @(negedge clk);
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_data !== (a1 - b1)) begin
            n_err++; $display("FAIL rst_mid_rsp1 got vld=%b id=%0d data=%h exp vld=1 id=1 data=%h", bus.rsp_valid, bus.rsp_id, bus.rsp_data, a1 - b1);
        end
        n_checks++; if (bus.req_ready !== 4'b1000) begin n_err++; $display("FAIL rst_mid_grant3 got %b exp 1000", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd3 || bus.rsp_data !== (a3 & b3) || bus.rsp_err !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_rsp3 got vld=%b id=%0d data=%h exp vld=1 id=3 data=%h", bus.rsp_valid, bus.rsp_id, bus.rsp_data, a3 & b3);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_compare_shift();
        test_random_ops();
        test_round_robin();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
